// File: rtl/checksum_seq.sv
// checksum_seq
//   Streaming 16-bit ones-complement (Internet) checksum sequencer. Each 32-bit
//   input word contributes both of its 16-bit halves to a wide accumulator. The
//   carries are deferred and folded end-around once the last word arrives. The
//   complemented result is presented on a valid/ready output.
//
//   Ports
//     clk, rst_n              clock (rising edge), async active-low reset
//     s_valid/s_ready         input word handshake
//     s_data[31:0], s_last    packet word, end-of-packet marker
//     abort                   synchronous flush of the packet in progress
//     cs_valid/cs_ready       result handshake
//     cs_data[15:0], cs_err   checksum (0 on error), oversize-packet flag
//     busy                    sequencer not idle
module checksum_seq #(
  parameter int MAX_WORDS = 375,
  parameter int ACC_W     = 32,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic        abort,
  output logic        cs_valid,
  input  logic        cs_ready,
  output logic [15:0] cs_data,
  output logic        cs_err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, FOLD, DONE} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   word_sum;
  logic [ACC_W-1:0]   fold_sum;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               xfer;

  // Ready is a pure state decode. abort also masks it, so a word presented
  // together with abort is never seen as consumed by the upstream.
  assign s_ready  = ((state == IDLE) || (state == ACCUM) || (state == DRAIN)) && !abort;
  assign busy     = (state != IDLE);
  assign xfer     = s_valid && s_ready;

  assign word_sum = ACC_W'(s_data[31:16]) + ACC_W'(s_data[15:0]);
  // End-around carry: the bits above 16 are added back into the low half.
  assign fold_sum = ACC_W'(acc[ACC_W-1:16]) + ACC_W'(acc[15:0]);
  assign cnt_nxt  = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      cs_valid <= 1'b0;
      cs_data  <= '0;
      cs_err   <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      cs_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          acc   <= word_sum;
          cnt   <= CNT_W'(1);
          state <= s_last ? FOLD : ACCUM;
        end
        ACCUM: if (xfer) begin
          acc <= acc + word_sum;
          cnt <= cnt_nxt;
          if (s_last)                              state <= FOLD;
          // A word carrying s_last at exactly MAX_WORDS is still a legal packet.
          else if (cnt_nxt == CNT_W'(MAX_WORDS))   state <= DRAIN;
        end
        DRAIN: if (xfer && s_last) begin
          cs_data  <= '0;
          cs_err   <= 1'b1;
          cs_valid <= 1'b1;
          state    <= DONE;
        end
        FOLD: begin
          if (acc[ACC_W-1:16] == '0) begin
            cs_data  <= ~acc[15:0];
            cs_err   <= 1'b0;
            cs_valid <= 1'b1;
            state    <= DONE;
          end else begin
            acc <= fold_sum;
          end
        end
        DONE: if (cs_ready) begin
          cs_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
